capture_sequencer: RTL

Single-clock capture controller for the oscilloscope sample buffer. It sits between the ADC deserializer and the dual-port sample RAM. It sequences pre-trigger fill, trigger detection (level/slope or forced), post-trigger capture, and the handoff to the Pi. It generates every RAM write strobe and address, raises the Pi-ready flag, and rearms when the Pi reports readout complete.

---
 rtl/oscope_pkg.sv | 16 +
 rtl/capture_sequencer_trig_detect.sv | 17 +
 rtl/capture_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/oscope_pkg.sv
// Shared types and default sizing for the oscilloscope capture path.
package oscope_pkg;

  typedef enum logic [1:0] {
    PREFILL = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READY   = 2'd3
  } capture_state_t;

  typedef logic [7:0] sample_t;

  localparam int DEFAULT_DEPTH    = 1024;
  localparam int DEFAULT_PRE_TRIG = 256;

endpackage

// File: rtl/capture_sequencer_trig_detect.sv
// Level/slope trigger compare between the previous and current ADC sample.
module trig_detect
  import oscope_pkg::*;
(
  input  sample_t prev,
  input  sample_t sample,
  input  sample_t trig_level,
  input  logic    trig_rising,
  output logic    hit
);

  always_comb begin
    if (trig_rising) hit = (prev < trig_level) && (sample >= trig_level);
    else             hit = (prev > trig_level) && (sample <= trig_level);
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture controller: pre-trigger fill, trigger, post-trigger capture, Pi handoff.
// Optional auto-trigger timeout enabled by defining CAPTURE_AUTO_TRIG_EN.
module capture_sequencer
  import oscope_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int PRE_TRIG = DEFAULT_PRE_TRIG
`ifdef CAPTURE_AUTO_TRIG_EN
  , parameter int AUTO_TIMEOUT = 65535
`endif
) (
  input  logic          osc_clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [7:0]    sample,
  input  logic [7:0]    trig_level,
  input  logic          trig_rising,
  input  logic          force_trig,
  input  logic          pi_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          pi_signal_flag,
  output logic [AW-1:0] start_addr,
  output logic [1:0]    state
);

  localparam logic [AW-1:0] PRE_LAST    = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] PRE_OFS     = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_WRITES = AW'(DEPTH - PRE_TRIG - 1);

  capture_state_t state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  post_cnt_q, post_cnt_d;
  logic [AW-1:0]  trig_ptr_q, trig_ptr_d;
  logic [AW-1:0]  start_addr_q, start_addr_d;
  sample_t        prev_q, prev_d;
  logic           prev_valid_q, prev_valid_d;
  logic           pend_q, pend_d;
  logic [2:0]     pi_sync_q, pi_sync_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  sample_t        wr_data_q, wr_data_d;

  logic slope_hit;
  logic auto_hit;
  logic pi_rise;
  logic write_now;

  trig_detect u_trig_detect (
    .prev        (prev_q),
    .sample      (sample),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .hit         (slope_hit)
  );

`ifdef CAPTURE_AUTO_TRIG_EN
  logic [31:0] auto_cnt_q, auto_cnt_d;

  // Saturates at the timeout so the pending request keeps being re-asserted.
  always_comb begin
    auto_cnt_d = '0;
    auto_hit   = 1'b0;
    if (state_q == ARMED) begin
      auto_hit   = (auto_cnt_q == 32'(AUTO_TIMEOUT));
      auto_cnt_d = auto_hit ? auto_cnt_q : auto_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) auto_cnt_q <= '0;
    else       auto_cnt_q <= auto_cnt_d;
  end
`else
  always_comb auto_hit = 1'b0;
`endif

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state_q      <= PREFILL;
      wr_ptr_q     <= '0;
      post_cnt_q   <= '0;
      trig_ptr_q   <= '0;
      start_addr_q <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      pi_sync_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      post_cnt_q   <= post_cnt_d;
      trig_ptr_q   <= trig_ptr_d;
      start_addr_q <= start_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      pend_q       <= pend_d;
      pi_sync_q    <= pi_sync_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // pi_sync_q[1:0] is the two-flop synchronizer; [2] delays it for edge detect.
  assign pi_rise = pi_sync_q[1] & ~pi_sync_q[2];

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    post_cnt_d   = post_cnt_q;
    trig_ptr_d   = trig_ptr_q;
    start_addr_d = start_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    pend_d       = 1'b0;
    pi_sync_d    = {pi_sync_q[1:0], pi_done};
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    write_now    = 1'b0;

    case (state_q)
      PREFILL: begin
        if (sample_valid) begin
          write_now    = 1'b1;
          prev_d       = sample;
          prev_valid_d = 1'b1;
          if (wr_ptr_q == PRE_LAST) state_d = ARMED;
        end
      end
      ARMED: begin
        pend_d = pend_q | force_trig | auto_hit;
        if (sample_valid) begin
          write_now    = 1'b1;
          prev_d       = sample;
          prev_valid_d = 1'b1;
          if (pend_d || (prev_valid_q && slope_hit)) begin
            state_d    = POST;
            trig_ptr_d = wr_ptr_q;
            post_cnt_d = '0;
            pend_d     = 1'b0;
          end
        end
      end
      POST: begin
        // The READY transition trails the last write by one cycle.
        if (post_cnt_q == POST_WRITES) begin
          state_d      = READY;
          start_addr_d = trig_ptr_q - PRE_OFS;
        end else if (sample_valid) begin
          write_now  = 1'b1;
          post_cnt_d = post_cnt_q + AW'(1);
        end
      end
      READY: begin
        if (pi_rise) begin
          state_d      = PREFILL;
          wr_ptr_d     = '0;
          prev_valid_d = 1'b0;
        end
      end
    endcase

    if (write_now) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_ptr_q;
      wr_data_d = sample;
      wr_ptr_d  = wr_ptr_q + AW'(1);
    end
  end

  always_comb begin
    wr_en          = wr_en_q;
    wr_addr        = wr_addr_q;
    wr_data        = wr_data_q;
    start_addr     = start_addr_q;
    pi_signal_flag = (state_q == READY);
    state          = state_q;
  end

endmodule
